// File: rtl/cache_mem_bridge_pkg.sv
// -----------------------------------------------------------------------------
// cache_mem_bridge_pkg
// Shared widths and state encodings for the cache-to-memory bridge.
//   Line_Width  : bits in one cache line
//   Word_Width  : bits in one memory word
//   Beat_Width  : bits in the beat index within a line
//   bridge_state_t : IDLE / WRITE / READ / DONE (2-bit encoding)
// -----------------------------------------------------------------------------
package cache_mem_bridge_pkg;

    localparam int Line_Width = 128;
    localparam int Word_Width = 32;
    localparam int Beat_Width = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } bridge_state_t;

endpackage

// File: rtl/cache_line_buffer.sv
// -----------------------------------------------------------------------------
// cache_line_buffer
// Four-word register file holding one cache line.
//   clk, rst   : clock, asynchronous active-low reset (clears all words)
//   load       : capture the whole line from line_in
//   we         : write word_in into word[idx] (ignored while load is high)
//   idx        : word index for we and for word_out
//   word_in    : single word to write
//   line_out   : all four words, word i at bits [WORD_W*i +: WORD_W]
//   word_out   : word[idx]
// -----------------------------------------------------------------------------
module cache_line_buffer #(
    parameter int WORD_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*WORD_W-1:0]   line_in,
    input  logic                  we,
    input  logic [1:0]            idx,
    input  logic [WORD_W-1:0]     word_in,
    output logic [4*WORD_W-1:0]   line_out,
    output logic [WORD_W-1:0]     word_out
);

    logic [WORD_W-1:0] words [4];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                words[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < 4; i++) begin
                words[i] <= line_in[i*WORD_W +: WORD_W];
            end
        end else if (we) begin
            words[idx] <= word_in;
        end
    end

    always_comb begin
        line_out = '0;
        for (int i = 0; i < 4; i++) begin
            line_out[i*WORD_W +: WORD_W] = words[i];
        end
    end

    assign word_out = words[idx];

endmodule

// File: rtl/cache_mem_bridge.sv
// -----------------------------------------------------------------------------
// cache_mem_bridge
// Turns one cache-line writeback or fill into four single-word beats on a
// req/ack memory port.
//   clk, rst   : clock, asynchronous active-low reset
//   Req_Low    : cache requests a line transfer (sampled in IDLE only)
//   Wr_Low     : 1 = writeback, 0 = fill (sampled with Req_Low)
//   A_Low      : line address, byte address bits [ADDR_W-1:4]
//   A_Word     : critical word of a fill (CACHE_CRITICAL_WORD_FIRST_EN only)
//   D_Low_in   : writeback line, word i at bits [32i+31:32i]
//   D_Low_out  : assembled fill line, same packing
//   Rdy_Low    : one-cycle completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata : beat request, held until mem_ack
//   mem_rdata/mem_ack : beat response; a beat completes when mem_req and
//                       mem_ack are both high at a rising edge
//   dbg_state  : current FSM state
// Handshake: mem_req is a valid that stays asserted with stable address/data
// until the cycle mem_ack is sampled high; mem_ack with mem_req low is ignored.
// Optional feature macro: CACHE_CRITICAL_WORD_FIRST_EN (fills start at A_Word).
// -----------------------------------------------------------------------------
module cache_mem_bridge
    import cache_mem_bridge_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int WORD_W         = 32,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Req_Low,
    input  logic                  Wr_Low,
    input  logic [ADDR_W-5:0]     A_Low,
    input  logic [1:0]            A_Word,
    input  logic [WORD_W*4-1:0]   D_Low_in,
    output logic [WORD_W*4-1:0]   D_Low_out,
    output logic                  Rdy_Low,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [WORD_W-1:0]     mem_wdata,
    input  logic [WORD_W-1:0]     mem_rdata,
    input  logic                  mem_ack,
    output logic [1:0]            dbg_state
);

    bridge_state_t              state_q, state_d;
    logic [Beat_Width-1:0]      beat_q, beat_d;
    logic [2:0]                 done_q, done_d;
    logic [ADDR_W-5:0]          line_q, line_d;
    logic [Beat_Width-1:0]      start_beat;
    logic                       wb_load;
    logic                       fill_we;
    logic [WORD_W-1:0]          wb_word;
    logic [WORD_W*4-1:0]        wb_line_unused;
    logic [WORD_W-1:0]          fill_word_unused;

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    // Fills fetch the requested word first; writebacks always run in order.
    assign start_beat = Wr_Low ? '0 : A_Word;
`else
    logic a_word_unused;
    assign a_word_unused = ^A_Word;
    assign start_beat    = '0;
`endif

    // Writeback data, captured at acceptance and read out one word per beat.
    cache_line_buffer #(.WORD_W(WORD_W)) u_wb_buf (
        .clk      (clk),
        .rst      (rst),
        .load     (wb_load),
        .line_in  (D_Low_in),
        .we       (1'b0),
        .idx      (beat_q),
        .word_in  ('0),
        .line_out (wb_line_unused),
        .word_out (wb_word)
    );

    // Fill assembly; its contents are the line the cache reads on Rdy_Low.
    cache_line_buffer #(.WORD_W(WORD_W)) u_fill_buf (
        .clk      (clk),
        .rst      (rst),
        .load     (1'b0),
        .line_in  ('0),
        .we       (fill_we),
        .idx      (beat_q),
        .word_in  (mem_rdata),
        .line_out (D_Low_out),
        .word_out (fill_word_unused)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            done_q  <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            done_q  <= done_d;
            line_q  <= line_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        done_d    = done_q;
        line_d    = line_q;
        wb_load   = 1'b0;
        fill_we   = 1'b0;
        Rdy_Low   = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        case (state_q)
            IDLE: begin
                if (Req_Low) begin
                    line_d  = A_Low;
                    wb_load = 1'b1;
                    beat_d  = start_beat;
                    done_d  = '0;
                    state_d = Wr_Low ? WRITE : READ;
                end
            end
            WRITE, READ: begin
                mem_req  = 1'b1;
                mem_we   = (state_q == WRITE);
                mem_addr = {line_q, beat_q, 2'b00};
                if (state_q == WRITE) begin
                    mem_wdata = wb_word;
                end
                if (mem_ack) begin
                    fill_we = (state_q == READ);
                    // Beat index wraps freely; the separate done count
                    // decides completion so critical-word-first works.
                    beat_d  = beat_q + 1'b1;
                    done_d  = done_q + 3'd1;
                    if (done_d == 3'(WORDS_PER_LINE)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // Req_Low may still be high here; it is not sampled until IDLE.
                Rdy_Low = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_cache_mem_bridge.sv
// -----------------------------------------------------------------------------
// tb_cache_mem_bridge
// Directed bench for cache_mem_bridge. Memory model returns the beat address
// as read data. Inputs change 1 ns after a rising edge; outputs are checked
// in the same window.
// -----------------------------------------------------------------------------
module tb_cache_mem_bridge;
    import cache_mem_bridge_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          Req_Low = 1'b0;
    logic          Wr_Low = 1'b0;
    logic [27:0]   A_Low = '0;
    logic [1:0]    A_Word = '0;
    logic [127:0]  D_Low_in = '0;
    logic [127:0]  D_Low_out;
    logic          Rdy_Low;
    logic          mem_req;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          mem_ack = 1'b0;
    logic [1:0]    dbg_state;

    int checks = 0;
    int failures = 0;

    cache_mem_bridge dut (
        .clk       (clk),
        .rst       (rst),
        .Req_Low   (Req_Low),
        .Wr_Low    (Wr_Low),
        .A_Low     (A_Low),
        .A_Word    (A_Word),
        .D_Low_in  (D_Low_in),
        .D_Low_out (D_Low_out),
        .Rdy_Low   (Rdy_Low),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .dbg_state (dbg_state)
    );

    // clock / memory model
    always #5 clk = ~clk;
    assign mem_rdata = mem_addr;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin : stim
        logic [31:0] fill_addr [4];
        logic [31:0] wb_data [4];
        logic [3:0]  cwf_nib [4];
        logic        exp_req, exp_we, exp_rdy;
        int          rdy_count;

        fill_addr = '{32'h1230, 32'h1234, 32'h1238, 32'h123C};
        wb_data   = '{32'hAAAA, 32'hBBBB, 32'hCCCC, 32'hDDDD};

        // ---------------- reset ----------------
        #2;
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_rdy", Rdy_Low, 1'b0);
        check("rst_dout", D_Low_out, 128'h0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_state", dbg_state, IDLE);
        tick();
        rst = 1'b1;
        tick();

        // ---------------- fill, ack tied high ----------------
        mem_ack = 1'b1;                 // ack while idle must be ignored
        Req_Low = 1'b1; Wr_Low = 1'b0; A_Low = 28'h0000123;
        check("f_c0_req", mem_req, 1'b0);
        tick();
        Req_Low = 1'b0;
        check("f_state_read", dbg_state, READ);
        for (int b = 0; b < 4; b++) begin
            check("f_req", mem_req, 1'b1);
            check("f_we", mem_we, 1'b0);
            check("f_addr", mem_addr, fill_addr[b]);
            check("f_rdy_low", Rdy_Low, 1'b0);
            tick();
        end
        check("f_c5_rdy", Rdy_Low, 1'b1);
        check("f_c5_req", mem_req, 1'b0);
        check("f_dout", D_Low_out, {32'h123C, 32'h1238, 32'h1234, 32'h1230});
        tick();
        check("f_c6_rdy", Rdy_Low, 1'b0);
        check("f_c6_state", dbg_state, IDLE);

        // ---------------- writeback, one wait per beat ----------------
        mem_ack = 1'b0;
        Req_Low = 1'b1; Wr_Low = 1'b1; A_Low = 28'h0000456;
        D_Low_in = {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA};
        tick();
        Req_Low = 1'b0;
        for (int b = 0; b < 4; b++) begin
            mem_ack = 1'b0;
            check("wb_wdata_a", mem_wdata, wb_data[b]);
            check("wb_we", mem_we, 1'b1);
            check("wb_addr", mem_addr, {28'h0000456, 2'(b), 2'b00});
            check("wb_rdy_a", Rdy_Low, 1'b0);
            tick();
            mem_ack = 1'b1;
            check("wb_wdata_b", mem_wdata, wb_data[b]);
            check("wb_rdy_b", Rdy_Low, 1'b0);
            tick();
        end
        mem_ack = 1'b0;
        check("wb_c9_rdy", Rdy_Low, 1'b1);
        check("wb_c9_req", mem_req, 1'b0);
        check("wb_c9_wdata", mem_wdata, 32'h0);
        check("wb_dout_kept", D_Low_out, {32'h123C, 32'h1238, 32'h1234, 32'h1230});
        tick();

        // ---------------- back-to-back WB then fill ----------------
        mem_ack = 1'b1;
        A_Low = 28'h0000200;
        rdy_count = 0;
        for (int k = 0; k < 13; k++) begin
            Wr_Low  = (k <= 5);
            Req_Low = (k <= 10);
            exp_req = (k >= 1 && k <= 4) || (k >= 7 && k <= 10);
            exp_we  = (k >= 1 && k <= 4);
            exp_rdy = (k == 5) || (k == 11);
            check($sformatf("b2b_req_c%0d", k), mem_req, exp_req);
            check($sformatf("b2b_we_c%0d", k), mem_we, exp_we);
            check($sformatf("b2b_rdy_c%0d", k), Rdy_Low, exp_rdy);
            if (Rdy_Low === 1'b1) rdy_count++;
            tick();
        end
        check("b2b_rdy_count", 32'(rdy_count), 32'd2);
        check("b2b_dout", D_Low_out, {32'h200C, 32'h2008, 32'h2004, 32'h2000});

        // ---------------- Req dropped / inputs changed mid-burst ----------------
        Req_Low = 1'b1; Wr_Low = 1'b1; A_Low = 28'h0ABCDEF;
        D_Low_in = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        tick();
        check("drop_b0", mem_wdata, 32'h11111111);
        tick();
        check("drop_b1", mem_wdata, 32'h22222222);
        tick();
        Req_Low = 1'b0; Wr_Low = 1'b0; A_Low = 28'h0; D_Low_in = {4{32'hFFFFFFFF}};
        check("drop_b2", mem_wdata, 32'h33333333);
        check("drop_b2_addr", mem_addr, 32'hABCDEF8);
        check("drop_b2_we", mem_we, 1'b1);
        tick();
        check("drop_b3", mem_wdata, 32'h44444444);
        check("drop_b3_addr", mem_addr, 32'hABCDEFC);
        tick();
        check("drop_rdy", Rdy_Low, 1'b1);
        check("drop_dout_kept", D_Low_out, {32'h200C, 32'h2008, 32'h2004, 32'h2000});
        tick();
        check("drop_rdy_once", Rdy_Low, 1'b0);
        check("drop_idle_req", mem_req, 1'b0);

        // ---------------- async reset mid-fill ----------------
        Req_Low = 1'b1; Wr_Low = 1'b0; A_Low = 28'h0000123;
        tick();
        Req_Low = 1'b0;
        tick();
        tick();
        check("rst_mid_addr", mem_addr, 32'h1238);
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_req", mem_req, 1'b0);
        check("rst_mid_rdy", Rdy_Low, 1'b0);
        check("rst_mid_dout", D_Low_out, 128'h0);
        check("rst_mid_addr0", mem_addr, 32'h0);
        #1;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("post_rst_req", mem_req, 1'b0);
            check("post_rst_state", dbg_state, IDLE);
        end

        // ---------------- fill with A_Word = 3 ----------------
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
        cwf_nib = '{4'hC, 4'h0, 4'h4, 4'h8};
`else
        cwf_nib = '{4'h0, 4'h4, 4'h8, 4'hC};
`endif
        mem_ack = 1'b1;
        Req_Low = 1'b1; Wr_Low = 1'b0; A_Low = 28'h0000123; A_Word = 2'd3;
        tick();
        Req_Low = 1'b0; A_Word = 2'd0;
        for (int b = 0; b < 4; b++) begin
            check("cwf_nib", mem_addr[3:0], cwf_nib[b]);
            check("cwf_req", mem_req, 1'b1);
            tick();
        end
        check("cwf_rdy", Rdy_Low, 1'b1);
        check("cwf_dout", D_Low_out, {32'h123C, 32'h1238, 32'h1234, 32'h1230});
        tick();
        check("cwf_idle", Rdy_Low, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
